// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit ripple adder stepped over the operand nibbles with a registered carry.
// Optional signed-overflow output is built when NSA_OVF_EN is defined.

module full_4bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef NSA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never drops without ready, and the DUT never overlaps accept with result.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] add_a, add_b, add_sum;
  logic       add_cout;
  logic       last_step;

  assign add_a     = a_q[{idx_q, 2'b00} +: 4];
  assign add_b     = b_q[{idx_q, 2'b00} +: 4];
  assign last_step = (idx_q == IW'(NIB - 1));

  full_4bit_adder u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = add_sum;
        carry_d = add_cout;
        if (last_step) begin
          idx_d   = '0;
          cout_d  = add_cout;
          // Top bit of the final nibble is the sign of the result.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NSA_OVF_EN
  assign ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): directed table, backpressure/reset sequences, random adds.
// Build with NSA_OVF_EN defined to also check the ovf port.

module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NSA_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Expected result records: {ovf, cout, sum}
  logic [WIDTH+1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef NSA_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer addition, overflow from operand/result signs.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    logic [WIDTH:0] full;
    logic           v;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    v    = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {v, full};
  endfunction

  task automatic check_result(input string name, input logic [WIDTH+1:0] e);
    chk({name, "_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
    chk({name, "_cout"}, 32'(cout), 32'(e[WIDTH]));
`ifdef NSA_OVF_EN
    chk({name, "_ovf"}, 32'(ovf), 32'(e[WIDTH+1]));
`endif
  endtask

  // Full transaction: offer operands, check latency, hold in DONE for `hold` cycles, then consume.
  task automatic run_add(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                         input int hold, input string name);
    logic [WIDTH+1:0] e;
    int               lat;
    int               waited;
    exp_q.push_back(model(xa, xb, xc));
    @(negedge clk);
    in_valid  = 1'b1;
    a         = xa;
    b         = xb;
    cin       = xc;
    out_ready = 1'b0;
    waited    = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'(xa ^ 16'hA5C3);
    b        = 16'(xb + 16'h1357);
    cin      = ~xc;
    chk({name, "_ready_in_run"}, 32'(in_ready), 32'd0);
    lat = 0;
    for (int e_i = 1; e_i <= 20; e_i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = e_i;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(NIB));
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = 16'h0001;
      b        = 16'h0001;
      cin      = 1'b0;
      chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check_result({name, "_hold"}, e);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_result(name, e);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH+1:0] m;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0, 1'b0};
    vecs[6] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef NSA_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: the model must agree with the hand-computed expectations, then the DUT with both.
    foreach (vecs[i]) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].cin);
      chk($sformatf("table%0d_model", i), 32'(m),
          32'({vecs[i].exp_ovf, vecs[i].exp_cout, vecs[i].exp_sum}));
      run_add(vecs[i].a, vecs[i].b, vecs[i].cin, 0, $sformatf("table%0d", i));
    end

    // Backpressure: 5 cycles held in DONE with a competing in_valid, then a clean follow-up add.
    run_add(16'h1234, 16'h4321, 1'b0, 5, "bp");
    run_add(16'h0FF0, 16'h0011, 1'b1, 0, "bp_next");

    // Reset after two RUN steps aborts the add.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h0F0F;
    b        = 16'h0101;
    cin      = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_add(16'h00FF, 16'h0001, 1'b0, 0, "after_abort");

    for (int r = 0; r < 30; r++) begin
      run_add(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
